nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor that computes d = a - b - bi one 4-bit slice per clock, least-significant slice first.
- Complements the ripple adder datapath: the adder produces sums, this block produces differences with borrow, reusing the same slice-and-ripple structure.
- Sits behind a start/busy/done handshake so a controller can run subtractions without a wide combinational borrow chain.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepted start cycle.
- b  input  WIDTH  subtrahend; sampled on the accepted start cycle.
- bi  input  1  borrow-in; sampled on the accepted start cycle.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when d, bo and ov are valid.
- d  output  WIDTH  difference a - b - bi, modulo 2^WIDTH.
- bo  output  1  borrow-out; 1 when a < b + bi, treating operands as unsigned.
- ov  output  1  signed overflow; 1 when (a[MSB] != b[MSB]) and (d[MSB] != a[MSB]).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0, d=0, bo=0, ov=0; internal operand registers, slice index and borrow register cleared.
- States:
  - IDLE: start=1 latches a, b, bi and sets slice index=0; next state RUN, busy=1 from the next cycle.
  - RUN: each cycle computes one SLICE-bit slice: diff = a_slice - b_slice - borrow.
    - Slice result is written into d[idx*SLICE +: SLICE]; the new borrow is registered.
    - idx increments each cycle.
    - After slice WIDTH/SLICE-1, next state DONE.
  - DONE: done=1 for exactly one cycle, busy=0, bo=final borrow, ov computed from latched a and b with final d; next state IDLE.
- Latency: start accepted in cycle N gives done=1 in cycle N+1+WIDTH/SLICE, i.e. N+5 at the default parameters.
- d holds its last result until the next accepted start. Slices are written progressively during RUN, so d is only guaranteed valid when done=1 and afterwards.
- bo and ov update only in DONE and hold until the next accepted start clears them.
- start while busy=1 or during the DONE cycle: ignored, no queuing. It is accepted again from IDLE, one cycle after done.
- start held high continuously: back-to-back operations, with one IDLE cycle between done and the next acceptance.
- a, b and bi may change freely after acceptance; only the latched copies are used.
- rst asserted mid-operation: the next edge forces IDLE and all reset values; no done pulse for the aborted operation.
- rst and start in the same cycle: rst wins; start is ignored.
- Wrap-around: results are modulo 2^WIDTH.
  - 0 - 1 gives d=all ones, bo=1.
  - bi=1 with a=b gives d=all ones, bo=1.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, RUN, DONE);
  - constants WIDTH_DEF=16, SLICE_DEF=4;
  - derived constant NSLICE=WIDTH/SLICE.
- Sub-module: four_bit_subtractor, a combinational SLICE-bit ripple borrow subtractor with ports a, b, bi, d, bo. It is instantiated once and muxed by the slice index. It is the subtraction counterpart of the existing 4-bit adder slice.

Test Plan:
- a=0x0005, b=0x0003, bi=0, start pulse in cycle 0 -> done=1 in cycle 5; d=0x0002, bo=0, ov=0; busy high in cycles 1-4.
- a=0x0000, b=0x0001, bi=0 -> d=0xFFFF, bo=1, ov=0.
- a=0x8000, b=0x0001, bi=0 -> d=0x7FFF, bo=0, ov=1. Then a=0x7FFF, b=0xFFFF -> d=0x8000, bo=1, ov=1.
- a=0x1234, b=0x0234, bi=1 -> d=0x0FFF, bo=0, ov=0. This exercises a borrow rippling across three slices.
- a=0x00FF, b=0x0001, start accepted; start re-pulsed in cycle 2 with a=0xFFFF -> single done in cycle 5 with d=0x00FE; no second done follows.
- start accepted, rst=1 in cycle 3 -> from cycle 4: busy=0, done=0, d=0x0000, bo=0, ov=0; no done pulse. A fresh start then completes normally in 5 cycles.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Contents:
//   state_t    - controller state encoding (IDLE, RUN, DONE)
//   WIDTH_DEF  - default operand/result width
//   SLICE_DEF  - default bits processed per clock
//   NSLICE     - number of slices per operation at the defaults
package nibble_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: d = a - b - bi.
// Subtraction counterpart of the 4-bit adder slice.
// Ports:
//   a  [SLICE-1:0] in   minuend slice
//   b  [SLICE-1:0] in   subtrahend slice
//   bi             in   borrow-in
//   d  [SLICE-1:0] out  difference slice
//   bo             out  borrow-out (1 when a < b + bi)
module four_bit_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bi,
    output logic [SLICE-1:0] d,
    output logic             bo
);

    // br[i] is the borrow into bit i; br[SLICE] leaves the slice.
    logic [SLICE:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < SLICE; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            // Borrow when a bit is 0 against a 1, or the bits match and a
            // borrow is already coming in.
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bo = br[SLICE];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bi, one SLICE-bit slice per clock,
// least-significant slice first, behind a start/busy/done handshake.
// Handshake: start is accepted only in IDLE (a, b, bi latched on that edge);
// busy is high for the WIDTH/SLICE RUN cycles; done pulses for one cycle when
// d, bo and ov are valid. start is ignored while busy or during done.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   request a new operation
//   a, b [WIDTH]  in   minuend / subtrahend
//   bi            in   borrow-in
//   busy          out  operation in progress
//   done          out  one-cycle result-valid pulse
//   d [WIDTH]     out  difference modulo 2^WIDTH
//   bo            out  unsigned borrow-out
//   ov            out  signed overflow
// WIDTH must be a multiple of SLICE.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov
);

    localparam int NS   = WIDTH / SLICE;
    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NS - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic             borrow_q;
    logic [IDXW-1:0]  idx;

    logic [SLICE-1:0] a_slice, b_slice, slice_d;
    logic             slice_bo;
    logic             last_slice;

    assign a_slice    = a_q[int'(idx)*SLICE +: SLICE];
    assign b_slice    = b_q[int'(idx)*SLICE +: SLICE];
    assign last_slice = (idx == LAST_IDX);

    four_bit_subtractor #(.SLICE(SLICE)) u_slice (
        .a  (a_slice),
        .b  (b_slice),
        .bi (borrow_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx      <= '0;
            d        <= '0;
            bo       <= 1'b0;
            ov       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bi;
                        idx      <= '0;
                        d        <= '0;
                        bo       <= 1'b0;
                        ov       <= 1'b0;
                    end
                end
                RUN: begin
                    d[int'(idx)*SLICE +: SLICE] <= slice_d;
                    borrow_q <= slice_bo;
                    idx      <= idx + 1'b1;
                    // The last slice carries the result MSB, so the flags can
                    // be registered here and be valid during the done cycle.
                    if (last_slice) begin
                        bo <= slice_bo;
                        ov <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (slice_d[SLICE-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bi;
    logic         busy, done, bo, ov;
    logic [W-1:0] d;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {d, bo, ov}
    logic [W+1:0] exp_q[$];

    nibble_serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo),
        .ov    (ov)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // One cycle: outputs are sampled and inputs driven 1 time unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic mbi);
        logic [W:0] r;
        logic       mov;
        r   = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbi);
        mov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        return {r[W-1:0], r[W], mov};
    endfunction

    // Driver: pulse start for one cycle and push the expected result.
    task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tbi);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bi    = tbi;
        exp_q.push_back(model(ta, tb, tbi));
    endtask

    // Runs one operation from the current cycle (cycle 0) and checks busy in
    // cycles 1-4, done in cycle 5 with the scoreboard result, then IDLE.
    task automatic test_op(input string name, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tbi);
        logic [W+1:0] e;
        bit           got;
        int           cyc;
        drive_start(ta, tb, tbi);
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bi    = 1'($urandom_range(0, 1));
        got   = 0;
        cyc   = 1;
        while (!got && cyc <= 8) begin
            if (done === 1'b1) begin
                got = 1;
                e   = exp_q.pop_front();
                checks++;
                if (cyc != 5) begin
                    errors++;
                    $display("FAIL %s latency: done in cycle %0d, required 5", name, cyc);
                end
                checks++;
                if ({d, bo, ov} !== e) begin
                    errors++;
                    $display("FAIL %s result: d=%h bo=%b ov=%b, required d=%h bo=%b ov=%b",
                             name, d, bo, ov, e[W+1:2], e[1], e[0]);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_in_done: busy=%b, required 0", name, busy);
                end
            end else begin
                if (cyc <= 4) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy cycle %0d: busy=%b, required 1", name, cyc, busy);
                    end
                end
                tick();
                cyc++;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: done=0 after 8 cycles, required 1 in cycle 5", name);
            exp_q.delete();
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b done=%b, required 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bi    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, done, d, bo, ov} !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b d=%h bo=%b ov=%b, required all 0",
                     busy, done, d, bo, ov);
        end
        // rst and start together: rst wins
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h0001;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_vs_start: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        test_op("basic", 16'h0005, 16'h0003, 1'b0);
    endtask

    task automatic test_wrap();
        test_op("zero_minus_one", 16'h0000, 16'h0001, 1'b0);
        test_op("equal_with_bi", 16'h5A5A, 16'h5A5A, 1'b1);
    endtask

    task automatic test_overflow();
        test_op("ov_neg_pos", 16'h8000, 16'h0001, 1'b0);
        test_op("ov_pos_neg", 16'h7FFF, 16'hFFFF, 1'b0);
    endtask

    task automatic test_borrow_ripple();
        test_op("borrow_ripple", 16'h1234, 16'h0234, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_op("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // start re-pulsed while busy must be ignored.
    task automatic test_ignore_start();
        logic [W+1:0] e;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            checks++;
            if (done !== (cyc == 5)) begin
                errors++;
                $display("FAIL ignore_start done cycle %0d: done=%b, required %b",
                         cyc, done, (cyc == 5));
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({d, bo, ov} !== e) begin
                    errors++;
                    $display("FAIL ignore_start result: d=%h bo=%b ov=%b, required d=%h bo=%b ov=%b",
                             d, bo, ov, e[W+1:2], e[1], e[0]);
                end
            end
            if (cyc == 0) begin
                drive_start(16'h00FF, 16'h0001, 1'b0);
            end else if (cyc == 2) begin
                start = 1'b1;
                a     = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    // start held high: second acceptance in the IDLE cycle after done.
    task automatic test_back_to_back();
        logic [W+1:0] e;
        for (int cyc = 0; cyc <= 13; cyc++) begin
            checks++;
            if (done !== (cyc == 5 || cyc == 11)) begin
                errors++;
                $display("FAIL back_to_back done cycle %0d: done=%b", cyc, done);
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({d, bo, ov} !== e) begin
                    errors++;
                    $display("FAIL back_to_back result: d=%h bo=%b ov=%b, required d=%h bo=%b ov=%b",
                             d, bo, ov, e[W+1:2], e[1], e[0]);
                end
            end
            if (cyc == 0) begin
                drive_start(16'hA000, 16'h0C01, 1'b1);
            end else if (cyc == 6) begin
                drive_start(16'h0003, 16'h8000, 1'b0);
            end else if (cyc < 6) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    // rst mid-operation aborts with no done pulse; a fresh op then works.
    task automatic test_reset_mid_op();
        for (int cyc = 0; cyc <= 9; cyc++) begin
            if (cyc == 4) begin
                checks++;
                if ({busy, done, d, bo, ov} !== '0) begin
                    errors++;
                    $display("FAIL abort_values: busy=%b done=%b d=%h bo=%b ov=%b, required all 0",
                             busy, done, d, bo, ov);
                end
            end
            if (cyc >= 4) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_done cycle %0d: done=%b, required 0", cyc, done);
                end
            end
            start = (cyc == 0);
            a     = 16'h4321;
            b     = 16'h1234;
            bi    = 1'b0;
            rst   = (cyc == 3);
            tick();
        end
        test_op("after_abort", 16'h0100, 16'h0001, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_borrow_ripple();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
